// File: rtl/i2c_scl_generator.sv
// I2C SCL generator: four equal quarter-phases per SCL period, with single-cycle phase ticks.
// Optional clock stretching is built in when I2C_SCL_STRETCH_EN is defined.
module i2c_scl_generator #(
    parameter int DIV_W   = 10,
    parameter int DIV_SM  = 124,
    parameter int DIV_FM  = 31,
    parameter int DIV_FMP = 12,
    parameter int DIV_HS  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] freq_mode,
    input  logic       scl_in,
    output logic       scl_out,
    output logic       fall_tick,
    output logic       data_tick,
    output logic       rise_tick,
    output logic       sample_tick,
    output logic [1:0] phase,
    output logic       stretching
);

    typedef enum logic [1:0] {
        PH_LOW0  = 2'd0,
        PH_LOW1  = 2'd1,
        PH_HIGH0 = 2'd2,
        PH_HIGH1 = 2'd3
    } phase_t;

    generate
        if (DIV_SM >= (1 << DIV_W) || DIV_FM >= (1 << DIV_W) ||
            DIV_FMP >= (1 << DIV_W) || DIV_HS >= (1 << DIV_W)) begin : g_div_range
            $error("i2c_scl_generator: a DIV_* terminal count does not fit in DIV_W bits");
        end
    endgenerate

    function automatic logic [DIV_W-1:0] div_sel(input logic [1:0] mode);
        logic [DIV_W-1:0] d;
        case (mode)
            2'b00:   d = DIV_W'(DIV_SM);
            2'b01:   d = DIV_W'(DIV_FM);
            2'b10:   d = DIV_W'(DIV_FMP);
            default: d = DIV_W'(DIV_HS);
        endcase
        return d;
    endfunction

    logic [DIV_W-1:0] cnt_r, cnt_nx;
    logic [DIV_W-1:0] div_r, div_nx;
    phase_t           ph_r, ph_nx;
    logic [3:0]       tick_r, tick_nx;
    logic             hold;

`ifdef I2C_SCL_STRETCH_EN
    // A slave keeping SCL low after we released it freezes the high quarter.
    assign hold = en && (ph_r == PH_HIGH0) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    always_comb begin
        cnt_nx  = cnt_r;
        ph_nx   = ph_r;
        div_nx  = div_r;
        tick_nx = 4'b0000;
        if (!en) begin
            cnt_nx = '0;
            ph_nx  = PH_HIGH1;
            div_nx = div_sel(freq_mode);
        end else if (!hold) begin
            if (cnt_r == div_r) begin
                cnt_nx = '0;
                ph_nx  = phase_t'(ph_r + 2'd1);
                case (ph_r)
                    PH_HIGH1: begin
                        tick_nx[0] = 1'b1;
                        // Divider only changes at a period boundary so no quarter is ever malformed.
                        div_nx     = div_sel(freq_mode);
                    end
                    PH_LOW0:  tick_nx[1] = 1'b1;
                    PH_LOW1:  tick_nx[2] = 1'b1;
                    default:  tick_nx[3] = 1'b1;
                endcase
            end else begin
                cnt_nx = cnt_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= '0;
            ph_r   <= PH_HIGH1;
            div_r  <= DIV_W'(DIV_SM);
            tick_r <= 4'b0000;
        end else begin
            cnt_r  <= cnt_nx;
            ph_r   <= ph_nx;
            div_r  <= div_nx;
            tick_r <= tick_nx;
        end
    end

    assign phase       = ph_r;
    assign scl_out     = ph_r[1];
    assign fall_tick   = tick_r[0];
    assign data_tick   = tick_r[1];
    assign rise_tick   = tick_r[2];
    assign sample_tick = tick_r[3];
    assign stretching  = hold;

endmodule

// File: tb/tb_i2c_scl_generator.sv
// Scoreboard bench for i2c_scl_generator: tick schedule predicted per episode from quarter arithmetic.
`timescale 1ns/1ps
module tb_i2c_scl_generator;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       en         = 1'b0;
    logic [1:0] freq_mode  = 2'b00;
    logic       slave_hold = 1'b0;
    logic       scl_in;
    logic       scl_out, fall_tick, data_tick, rise_tick, sample_tick, stretching;
    logic [1:0] phase;

    // Open-drain bus: SCL is low if either side pulls it low.
    assign scl_in = scl_out & ~slave_hold;

    always #5 clk = ~clk;

    i2c_scl_generator dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .freq_mode   (freq_mode),
        .scl_in      (scl_in),
        .scl_out     (scl_out),
        .fall_tick   (fall_tick),
        .data_tick   (data_tick),
        .rise_tick   (rise_tick),
        .sample_tick (sample_tick),
        .phase       (phase),
        .stretching  (stretching)
    );

`ifdef I2C_SCL_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    typedef struct {
        int at;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  edge_n   = 0;
    bit  sb_on    = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    function automatic int div_of(input int m);
        case (m)
            0:       return 124;
            1:       return 31;
            2:       return 12;
            default: return 3;
        endcase
    endfunction

    // Monitor: every tick is matched against the next predicted event.
    always @(negedge clk) begin
        logic [3:0] t;
        int         kind;
        ev_t        e;
        t = {sample_tick, rise_tick, data_tick, fall_tick};
        if (sb_on && t != 4'b0000) begin
            chk("one_tick", $countones(t), 1);
            kind = t[0] ? 0 : t[1] ? 1 : t[2] ? 2 : 3;
            if (exp_q.size() == 0) begin
                chk("unexpected_tick_edge", edge_n, -1);
            end else begin
                e = exp_q.pop_front();
                chk("tick_edge", edge_n, e.at);
                chk("tick_kind", kind, e.kind);
            end
            chk("tick_phase", int'(phase), kind);
            chk("tick_scl", int'(scl_out), kind / 2);
            chk("tick_stretching", int'(stretching), 0);
        end
    end

    // One enable window: idle in mode m0, run len cycles, optionally switch to m1 at offset chg_off.
    task automatic run_episode(input int m0, input int m1, input int chg_off, input int len);
        int  e_en, mc, dis, t, d, k;
        ev_t ev;
        @(negedge clk);
        en        = 1'b0;
        freq_mode = m0[1:0];
        repeat (2 + $urandom_range(0, 6)) @(negedge clk);
        en   = 1'b1;
        e_en = edge_n + 1;
        dis  = edge_n + len + 1;
        mc   = (chg_off > 0) ? edge_n + chg_off : 32'h7fff_ffff;
        t    = e_en - 1;
        d    = div_of(m0);
        k    = 0;
        while (1) begin
            t = t + d + 1;
            if (t >= dis) break;
            ev.at   = t;
            ev.kind = k % 4;
            exp_q.push_back(ev);
            if (k % 4 == 0) d = div_of((t > mc) ? m1 : m0);
            k++;
        end
        repeat (len) begin
            @(negedge clk);
            if (edge_n == mc) freq_mode = m1[1:0];
            slave_hold = STRETCH ? 1'b0 : 1'($urandom_range(0, 1));
        end
        en         = 1'b0;
        slave_hold = 1'b0;
        @(negedge clk);
        chk("idle_scl", int'(scl_out), 1);
        chk("idle_phase", int'(phase), 3);
        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, w, n, len, r, sc;
        logic [3:0] tk;

        reset = 1'b1;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl", int'(scl_out), 1);
        chk("rst_phase", int'(phase), 3);
        chk("rst_ticks", int'({sample_tick, rise_tick, data_tick, fall_tick}), 0);
        chk("rst_stretching", int'(stretching), 0);
        reset = 1'b0;
        bad   = 0;
        repeat (100) begin
            @(negedge clk);
            tk = {sample_tick, rise_tick, data_tick, fall_tick};
            if (scl_out !== 1'b1 || phase !== 2'd3 || tk != 4'b0000) bad++;
        end
        chk("idle_100_bad_cycles", bad, 0);

        sb_on = 1'b1;
        run_episode(0, 0, 0, 1100);
        run_episode(3, 1, 10, 300);
        run_episode(1, 2, 0, 200);
        for (int i = 0; i < 10; i++) begin
            len = $urandom_range(20, 700);
            run_episode($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, len), len);
        end
        sb_on = 1'b0;

        // Reset in the middle of a high quarter at HS speed.
        @(negedge clk);
        en        = 1'b0;
        freq_mode = 2'b11;
        repeat (3) @(negedge clk);
        en = 1'b1;
        w  = 0;
        while (phase != 2'd2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("reach_phase2", int'(phase), 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_phase", int'(phase), 3);
        chk("midrst_scl", int'(scl_out), 1);
        chk("midrst_ticks", int'({sample_tick, rise_tick, data_tick, fall_tick}), 0);
        reset = 1'b0;
        n     = edge_n;
        w     = 0;
        do begin
            @(negedge clk);
            w++;
        end while ({sample_tick, rise_tick, data_tick, fall_tick} == 4'b0000 && w < 300);
        chk("postrst_first_tick_delay", edge_n - n, 125);
        chk("postrst_first_tick_fall", int'(fall_tick), 1);
        en = 1'b0;
        repeat (3) @(negedge clk);

`ifdef I2C_SCL_STRETCH_EN
        freq_mode = 2'b10;
        repeat (3) @(negedge clk);
        en = 1'b1;
        w  = 0;
        while (!rise_tick && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("stretch_rise_seen", int'(rise_tick), 1);
        r          = edge_n;
        slave_hold = 1'b1;
        sc         = 0;
        #1;
        repeat (40) begin
            if (stretching) sc++;
            @(negedge clk);
            #1;
        end
        chk("stretch_cycles", sc, 40);
        slave_hold = 1'b0;
        #1;
        chk("stretch_released", int'(stretching), 0);
        w = 0;
        while (!sample_tick && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("stretch_sample_delay", edge_n - (r + 40), 13);
        en = 1'b0;
        @(negedge clk);
        chk("stretch_idle_clear", int'(stretching), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
